lab3_exerciser: RTL

- Self-checking stimulus/response engine for the team's 3-input/2-output gate-level lab logic (inputs a, b, c; outputs x, y).
- Acts as the driving end of that interface: sweeps all 8 input combinations on a, b, c, waits a settle time, samples x and y, and compares them against a built-in golden model.
- Reports pass/fail, an error count and the first failing vector.
- Sits on the board/top level between the lab logic and the LEDs/switches.

---
 rtl/lab3_exerciser.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/lab3_exerciser.sv
// Stimulus/response engine for the 3-input/2-output lab logic: sweeps a,b,c
// through all eight vectors, samples x/y after a settle time and tallies mismatches.
module lab3_exerciser #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             x,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       first_fail
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [2:0]       first_q, first_d;
    logic             seen_q, seen_d;

    logic             gd;
    logic             x_exp;
    logic             y_exp;
    logic             mismatch;
    logic [ERR_W-1:0] err_inc;

    // Golden model of the lab logic, evaluated on the vector currently driven.
    always_comb begin
        gd       = vec_q[2] | vec_q[1];
        x_exp    = gd ^ ~vec_q[0];
        y_exp    = (gd ^ ~(vec_q[2] & vec_q[1])) & gd;
        mismatch = (x != x_exp) || (y != y_exp);
        err_inc  = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        first_d = first_q;
        seen_d  = seen_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    vec_d   = 3'd0;
                    err_d   = '0;
                    first_d = 3'd0;
                    seen_d  = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                cnt_d   = 4'(SETTLE_CYCLES - 1);
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_inc;
                    if (!seen_q) begin
                        first_d = vec_q;
                        seen_d  = 1'b1;
                    end
                end
                // Pass must reflect the compare made on this very edge.
                if (vec_q != 3'd7) begin
                    vec_d   = vec_q + 3'd1;
                    state_d = DRIVE;
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (mismatch ? err_inc : err_q) == '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 3'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= 3'd0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
            seen_q  <= seen_d;
        end
    end

    assign a          = vec_q[2];
    assign b          = vec_q[1];
    assign c          = vec_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign first_fail = first_q;

endmodule
